i2c_master_bit_engine: RTL and testbench
========================================

Name: i2c_master_bit_engine

Overview:
- Synthesizable I2C master byte engine that sits directly upstream of the open-drain bus interface.
- Produces the per-line drive controls scl_drive and sda_drive (1 = release, 0 = pull low) and samples the resolved bus lines scl_in and sda_in.
- Accepts byte-level commands (START, WRITE, READ, STOP) over a valid/ready handshake and returns one response per command.
- Supports clock stretching by targets and multi-master arbitration-loss detection.

Parameters:
CLK_DIV, 250, clk cycles per quarter SCL period; must be >= 2; nominal bit time = 4*CLK_DIV cycles
STRETCH_MAX, 65535, max clk cycles SCL may be held low by another agent in phase C (used only with the optional feature)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  engine can accept a command
cmd_op  in  3  1=START (also repeated start), 2=WRITE, 3=READ, 4=STOP; other values illegal
cmd_data  in  8  byte for WRITE, sent MSB first
cmd_ack_in  in  1  SDA level driven in the READ ack slot (0=ACK, 1=NACK)
rsp_valid  out  1  single-cycle completion pulse
rsp_data  out  8  byte received by READ; 0 for other ops
rsp_nack  out  1  WRITE: target NACKed; also set for illegal op
rsp_arb_lost  out  1  arbitration lost during this command
rsp_timeout  out  1  SCL stretch timeout (optional feature only; otherwise tied 0)
busy  out  1  command in progress
bus_owned  out  1  engine holds the bus (after START, until STOP/arb loss/timeout/reset)
scl_drive  out  1  SCL control, 1 = release
sda_drive  out  1  SDA control, 1 = release
scl_in  in  1  resolved SCL, already synchronized
sda_in  in  1  resolved SDA, already synchronized

Behaviour:
- Reset values: scl_drive=1, sda_drive=1, cmd_ready=0 while rst is high and 1 the cycle after rst falls, rsp_valid=0, busy=0, bus_owned=0, rsp_* = 0. Reset mid-command aborts immediately and releases both lines on the next edge; no response is issued.
- Handshake: cmd_ready=1 only in IDLE. A command is accepted on cmd_valid && cmd_ready. busy rises the next cycle. The command fields are captured at acceptance.
- Response: rsp_valid pulses exactly one cycle after the last quarter of a command. cmd_ready returns the cycle after rsp_valid. rsp_* fields are held until the next response.
- Illegal op: rsp_valid with rsp_nack=1 in the cycle after acceptance; no bus activity.
- Quarter timer: counts CLK_DIV cycles per quarter. Each bit is 4 quarters:
  - A: SCL low; set sda_drive to the bit value.
  - B: SCL low, hold.
  - C: release SCL; the timer freezes while scl_in=0 (stretch). sda_in is sampled on the final cycle of C.
  - D: SCL high; pull SCL low at the end of D.
- States: IDLE, START, WBIT, WACK, RBIT, RACK, STOP, RESP.
- START, 4 quarters:
  - Q1: release SDA and SCL (wait on scl_in=1 as in C).
  - Q2: hold.
  - Q3: sda_drive=0.
  - Q4: scl_drive=0.
  - A repeated start while bus_owned uses the same sequence.
  - Sets bus_owned.
- WRITE: 8 WBIT bits, then WACK with SDA released. rsp_nack = sda_in sampled in the ack slot.
- READ: 8 RBIT bits with SDA released; sampled bits are shifted MSB-first into rsp_data. RACK drives cmd_ack_in.
- STOP, 4 quarters:
  - Q1: SDA low, SCL low.
  - Q2: release SCL, stretch-aware.
  - Q3: hold.
  - Q4: release SDA.
  - Clears bus_owned.
- WRITE/READ/STOP issued while bus_owned=0 still execute as specified; no error is flagged.
- Arbitration: in any phase where sda_drive=1 and the engine expects SDA high (WRITE data bits, START Q1/Q2, STOP Q4), sampling sda_in=0 means arbitration lost. The engine then:
  - releases both lines next cycle;
  - clears bus_owned;
  - issues a response with rsp_arb_lost=1 (rsp_data holds bits shifted so far);
  - returns to IDLE.
- Simultaneous cmd_valid and rsp_valid: the command is not accepted that cycle (cmd_ready=0).

Optional Feature:
- Macro I2C_STRETCH_TIMEOUT_EN.
- Defined: a counter runs while the engine waits for scl_in=1 with scl_drive=1. Reaching STRETCH_MAX cycles:
  - releases both lines;
  - clears bus_owned;
  - issues a response with rsp_timeout=1;
  - goes to IDLE.
- Undefined: the wait is unbounded and rsp_timeout is constant 0.

Test Plan (CLK_DIV=4):
- START, then WRITE 0xA5 with the target model ACKing -> SDA pattern 1,0,1,0,0,1,0,1 sampled on SCL rising edges; rsp_nack=0; WRITE takes 144 cycles, and rsp_valid pulses at cycle 145 after acceptance.
- READ with the model returning 0x3C and cmd_ack_in=1 -> rsp_data=0x3C; SDA released (1) in the 9th SCL high; then STOP -> SDA rises while SCL=1; bus_owned=0.
- Model holds SCL low 50 cycles during bit 3 of WRITE 0x00 -> the bit's high phase starts after the release; total time extends by about 50 cycles; the data sent is unchanged.
- Second master pulls SDA low during bit 1 of WRITE 0xFF -> rsp_arb_lost=1; scl_drive=sda_drive=1 the next cycle; bus_owned=0.
- With I2C_STRETCH_TIMEOUT_EN and STRETCH_MAX=20, SCL held low 100 cycles -> rsp_timeout=1 at 20 cycles; both lines released.
- Assert rst for 1 cycle in the middle of READ -> the next cycle has scl_drive=sda_drive=1, busy=0, no rsp_valid, and cmd_ready=1 one cycle after rst falls; cmd_op=6 -> rsp_nack=1 with no bus toggling.

Source files
------------

// File: rtl/i2c_master_bit_engine.sv
// i2c_master_bit_engine: I2C master byte engine (START/WRITE/READ/STOP, stretch, arbitration); define I2C_STRETCH_TIMEOUT_EN for SCL stretch timeout
module i2c_master_bit_engine #(
  parameter int CLK_DIV = 250,
  parameter int STRETCH_MAX = 65535
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [7:0] cmd_data,
  input  logic       cmd_ack_in,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_nack,
  output logic       rsp_arb_lost,
  output logic       rsp_timeout,
  output logic       busy,
  output logic       bus_owned,
  output logic       scl_drive,
  output logic       sda_drive,
  input  logic       scl_in,
  input  logic       sda_in
);
  typedef enum logic [2:0] {IDLE, START, WBIT, WACK, RBIT, RACK, STOP, RESP} state_t;
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
  if (CLK_DIV < 2 || STRETCH_MAX < 1) begin : g_bad_param
    $error("i2c_master_bit_engine: CLK_DIV must be >= 2 and STRETCH_MAX >= 1");
  end
  state_t state_q, state_d;
  logic [1:0] q_q, q_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] n_q, n_d, op_q, op_d;
  logic [7:0] dat_q, dat_d, sh_q, sh_d, rdata_q, rdata_d;
  logic ack_q, ack_d, nk_q, nk_d, scl_q, scl_d, sda_q, sda_d, ready_q, ready_d, busy_q, busy_d;
  logic rv_q, rv_d, rnack_q, rnack_d, rarb_q, rarb_d, rto_q, rto_d, own_q, own_d;
  logic bit_st, bit_d, stretch, hold, qend, samp, arb, to, abort;
  assign bit_st = state_q inside {WBIT, WACK, RBIT, RACK};
  assign bit_d = state_d inside {WBIT, WACK, RBIT, RACK};
  assign stretch = (state_q == START && q_q == 2'd0) || (bit_st && q_q == 2'd2) || (state_q == STOP && q_q == 2'd1);
  assign hold = stretch && !scl_in;
  assign qend = cnt_q == LAST && !hold;
  assign samp = qend && ((bit_st && q_q == 2'd2) || (state_q == START && !q_q[1]) || (state_q == STOP && q_q == 2'd3));
  assign arb = samp && !sda_in && ((state_q == WBIT && dat_q[3'd7 - n_q]) || state_q == START || state_q == STOP);
  assign abort = arb || to;
`ifdef I2C_STRETCH_TIMEOUT_EN
  localparam int TW = $clog2(STRETCH_MAX + 1);
  logic [TW-1:0] tc_q, tc_d;
  always_comb begin
    tc_d = (hold && scl_q) ? tc_q + 1'b1 : '0;
    to = hold && scl_q && tc_q == TW'(STRETCH_MAX - 1);
  end
  always_ff @(posedge clk) tc_q <= rst ? '0 : tc_d;
`else
  assign to = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    q_d = q_q;
    cnt_d = cnt_q;
    n_d = n_q;
    op_d = op_q;
    dat_d = dat_q;
    ack_d = ack_q;
    sh_d = sh_q;
    nk_d = nk_q;
    own_d = own_q;
    rdata_d = rdata_q;
    rnack_d = rnack_q;
    rarb_d = rarb_q;
    rto_d = rto_q;
    if (state_q == IDLE && cmd_valid && ready_q) begin
      op_d = cmd_op;
      dat_d = cmd_data;
      ack_d = cmd_ack_in;
      q_d = '0;
      cnt_d = '0;
      n_d = '0;
      sh_d = '0;
      nk_d = 1'b0;
      state_d = cmd_op == 3'd1 ? START : cmd_op == 3'd2 ? WBIT : cmd_op == 3'd3 ? RBIT : cmd_op == 3'd4 ? STOP : RESP;
    end else if (state_q == RESP) begin
      state_d = IDLE;
    end else if (state_q != IDLE) begin
      cnt_d = hold ? cnt_q : qend ? '0 : cnt_q + 1'b1;
      q_d = qend ? q_q + 2'd1 : q_q;
      if (samp && (state_q == WBIT || state_q == RBIT)) sh_d = {sh_q[6:0], sda_in};
      if (samp && state_q == WACK) nk_d = sda_in;
      if (qend && q_q == 2'd3) begin
        n_d = bit_st ? n_q + 3'd1 : n_q;
        state_d = state_q == WBIT ? (n_q == 3'd7 ? WACK : WBIT) : state_q == RBIT ? (n_q == 3'd7 ? RACK : RBIT) : RESP;
        own_d = state_q == START ? 1'b1 : state_q == STOP ? 1'b0 : own_q;
      end
      if (abort) begin
        state_d = RESP;
        own_d = 1'b0;
      end
    end
    if (state_d == RESP && state_q != RESP) begin
      rdata_d = (op_d == 3'd3 || arb) ? sh_d : 8'd0;
      rnack_d = (op_d == 3'd2 && nk_d) || op_d == 3'd0 || op_d > 3'd4;
      rarb_d = arb;
      rto_d = to;
    end
    scl_d = abort ? 1'b1 : state_d == START ? q_d != 2'd3 : state_d == STOP ? q_d != 2'd0 : bit_d ? q_d[1] : scl_q && !bit_st;
    sda_d = abort ? 1'b1 : state_d == START ? !q_d[1] : state_d == STOP ? q_d == 2'd3 :
            state_d == WBIT ? dat_d[3'd7 - n_d] : state_d == RACK ? ack_d : bit_d ? 1'b1 : sda_q;
    ready_d = state_d == IDLE;
    busy_d = state_d != IDLE;
    rv_d = state_d == RESP;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      q_q <= '0;
      cnt_q <= '0;
      n_q <= '0;
      op_q <= '0;
      dat_q <= '0;
      ack_q <= 1'b0;
      sh_q <= '0;
      nk_q <= 1'b0;
      own_q <= 1'b0;
      rdata_q <= '0;
      rnack_q <= 1'b0;
      rarb_q <= 1'b0;
      rto_q <= 1'b0;
      scl_q <= 1'b1;
      sda_q <= 1'b1;
      ready_q <= 1'b0;
      busy_q <= 1'b0;
      rv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q <= q_d;
      cnt_q <= cnt_d;
      n_q <= n_d;
      op_q <= op_d;
      dat_q <= dat_d;
      ack_q <= ack_d;
      sh_q <= sh_d;
      nk_q <= nk_d;
      own_q <= own_d;
      rdata_q <= rdata_d;
      rnack_q <= rnack_d;
      rarb_q <= rarb_d;
      rto_q <= rto_d;
      scl_q <= scl_d;
      sda_q <= sda_d;
      ready_q <= ready_d;
      busy_q <= busy_d;
      rv_q <= rv_d;
    end
  end
  assign cmd_ready = ready_q;
  assign rsp_valid = rv_q;
  assign rsp_data = rdata_q;
  assign rsp_nack = rnack_q;
  assign rsp_arb_lost = rarb_q;
  assign rsp_timeout = rto_q;
  assign busy = busy_q;
  assign bus_owned = own_q;
  assign scl_drive = scl_q;
  assign sda_drive = sda_q;
endmodule

// File: tb/tb_i2c_master_bit_engine.sv
// tb_i2c_master_bit_engine: directed checks of the I2C master byte engine against a small bus and target model
module tb_i2c_master_bit_engine;
  logic clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, cmd_ack_in = 1'b0;
  logic [2:0] cmd_op = '0;
  logic [7:0] cmd_data = '0, rsp_data;
  logic cmd_ready, rsp_valid, rsp_nack, rsp_arb_lost, rsp_timeout, busy, bus_owned, scl_drive, sda_drive, scl_in, sda_in;
  int vecs = 0, errs = 0, n = 0, s0 = 0, f0 = 0;
  int rises = 0, falls = 0, stops = 0, rise_base = 0, fall_base = 0, hold_cnt = 0, str_len = 0, str_bit = 0, fdiff;
  logic scl_p = 1'b1, sda_p = 1'b1, tgt_ack = 1'b0, rd_mode = 1'b0, m2_en = 1'b0, seen = 1'b0;
  logic [7:0] rd_byte = '0;
  logic rise_sda [0:31];
`ifdef I2C_STRETCH_TIMEOUT_EN
  localparam int STR = 15;
`else
  localparam int STR = 50;
`endif
  i2c_master_bit_engine #(.CLK_DIV(4), .STRETCH_MAX(20)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_ack_in(cmd_ack_in), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_nack(rsp_nack), .rsp_arb_lost(rsp_arb_lost), .rsp_timeout(rsp_timeout), .busy(busy),
    .bus_owned(bus_owned), .scl_drive(scl_drive), .sda_drive(sda_drive), .scl_in(scl_in), .sda_in(sda_in)
  );
  always #5 clk = ~clk;
  assign fdiff = falls - fall_base;
  assign scl_in = scl_drive && !(str_len != 0 && fdiff == str_bit && hold_cnt < str_len);
  assign sda_in = sda_drive && !(tgt_ack && fdiff == 8) && !(rd_mode && fdiff < 8 && !rd_byte[3'(7 - fdiff)]) && !(m2_en && fdiff == 1);
  always @(posedge clk) begin
    scl_p <= scl_in;
    sda_p <= sda_in;
    if (scl_in && !scl_p) begin
      rise_sda[rises % 32] <= sda_in;
      rises <= rises + 1;
    end
    if (!scl_in && scl_p) falls <= falls + 1;
    if (scl_in && scl_p && sda_in && !sda_p) stops <= stops + 1;
    hold_cnt <= str_len == 0 ? 0 : (scl_drive && !scl_in && fdiff == str_bit && hold_cnt < str_len) ? hold_cnt + 1 : hold_cnt;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic issue(input logic [2:0] op, input logic [7:0] d, input logic a);
    int w = 0;
    @(negedge clk);
    cmd_op = op;
    cmd_data = d;
    cmd_ack_in = a;
    cmd_valid = 1'b1;
    while (!cmd_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("ready_wait", cmd_ready, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    rise_base = rises;
    fall_base = falls;
  endtask
  task automatic wait_rsp(output int cnt);
    cnt = 0;
    while (!rsp_valid && cnt < 5000) begin
      @(posedge clk);
      #1;
      cnt++;
    end
  endtask
  task automatic run(input logic [2:0] op, input logic [7:0] d, input logic a, output int cnt);
    issue(op, d, a);
    wait_rsp(cnt);
  endtask
  function automatic logic [8:0] rise_bits();
    logic [8:0] b = '0;
    for (int k = 0; k < 9; k++) b = {b[7:0], rise_sda[(rise_base + k) % 32]};
    return b;
  endfunction
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_scl", scl_drive, 1);
    chk("rst_sda", sda_drive, 1);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owned", bus_owned, 0);
    chk("rst_rv", rsp_valid, 0);
    chk("rst_rsp", {rsp_data, rsp_nack, rsp_arb_lost, rsp_timeout}, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_rst", cmd_ready, 1);
    run(3'd1, 8'h00, 1'b0, n);
    chk("start_cycles", n, 16);
    chk("start_owned", bus_owned, 1);
    chk("start_lines", {scl_drive, sda_drive}, 0);
    chk("start_busy", busy, 1);
    tgt_ack = 1'b1;
    run(3'd2, 8'hA5, 1'b0, n);
    tgt_ack = 1'b0;
    chk("wr_a5_cycles", n, 144);
    chk("wr_a5_bits", rise_bits(), 9'h14A);
    chk("wr_a5_rises", rises - rise_base, 9);
    chk("wr_a5_flags", {rsp_nack, rsp_arb_lost, rsp_timeout}, 0);
    chk("wr_a5_data", rsp_data, 0);
    chk("wr_a5_owned", bus_owned, 1);
    @(posedge clk);
    #1;
    chk("rsp_one_cycle", rsp_valid, 0);
    chk("ready_after_rsp", cmd_ready, 1);
    chk("rsp_held", rsp_nack, 0);
    run(3'd2, 8'h5A, 1'b0, n);
    chk("wr_5a_cycles", n, 144);
    chk("wr_5a_bits", rise_bits(), 9'h0B5);
    chk("wr_5a_nack", rsp_nack, 1);
    rd_mode = 1'b1;
    rd_byte = 8'h3C;
    run(3'd3, 8'h00, 1'b1, n);
    rd_mode = 1'b0;
    chk("rd_cycles", n, 144);
    chk("rd_data", rsp_data, 8'h3C);
    chk("rd_bits", rise_bits(), 9'h079);
    chk("rd_nack", rsp_nack, 0);
    s0 = stops;
    run(3'd4, 8'h00, 1'b0, n);
    chk("stop_cycles", n, 16);
    chk("stop_cond", stops - s0, 1);
    chk("stop_owned", bus_owned, 0);
    chk("stop_lines", {scl_drive, sda_drive}, 2'b11);
    run(3'd1, 8'h00, 1'b0, n);
    str_bit = 3;
    str_len = STR;
    tgt_ack = 1'b1;
    run(3'd2, 8'h00, 1'b0, n);
    tgt_ack = 1'b0;
    chk("str_cycles", n, 144 + STR);
    chk("str_held", hold_cnt, STR);
    chk("str_bits", rise_bits(), 9'h000);
    chk("str_flags", {rsp_nack, rsp_arb_lost, rsp_timeout}, 0);
    str_len = 0;
    m2_en = 1'b1;
    run(3'd2, 8'hFF, 1'b0, n);
    chk("arb_cycles", n, 28);
    chk("arb_flags", {rsp_nack, rsp_arb_lost, rsp_timeout}, 3'b010);
    chk("arb_lines", {scl_drive, sda_drive}, 2'b11);
    chk("arb_owned", bus_owned, 0);
    m2_en = 1'b0;
`ifdef I2C_STRETCH_TIMEOUT_EN
    run(3'd1, 8'h00, 1'b0, n);
    str_bit = 0;
    str_len = 100;
    run(3'd2, 8'h80, 1'b0, n);
    chk("to_cycles", n, 28);
    chk("to_flags", {rsp_arb_lost, rsp_timeout}, 2'b01);
    chk("to_lines", {scl_drive, sda_drive}, 2'b11);
    chk("to_owned", bus_owned, 0);
    str_len = 0;
`endif
    run(3'd1, 8'h00, 1'b0, n);
    rd_mode = 1'b1;
    rd_byte = 8'hC3;
    issue(3'd3, 8'h00, 1'b0);
    repeat (40) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst_lines", {scl_drive, sda_drive}, 2'b11);
    chk("mrst_busy", busy, 0);
    chk("mrst_rv", rsp_valid, 0);
    chk("mrst_ready", cmd_ready, 0);
    chk("mrst_owned", bus_owned, 0);
    @(negedge clk) rst = 1'b0;
    rd_mode = 1'b0;
    @(posedge clk);
    #1;
    chk("mrst_ready_after", cmd_ready, 1);
    seen = rsp_valid;
    repeat (20) begin
      @(posedge clk);
      #1;
      seen = seen | rsp_valid;
    end
    chk("mrst_no_rsp", seen, 0);
    f0 = falls + rises;
    run(3'd6, 8'h00, 1'b0, n);
    chk("ill_cycles", n, 0);
    chk("ill_flags", {rsp_nack, rsp_arb_lost, rsp_timeout}, 3'b100);
    chk("ill_data", rsp_data, 0);
    chk("ill_lines", {scl_drive, sda_drive}, 2'b11);
    repeat (3) @(posedge clk);
    #1;
    chk("ill_no_toggle", falls + rises - f0, 0);
    @(negedge clk);
    cmd_op = 3'd6;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("sim_rv1", rsp_valid, 1);
    chk("sim_ready0", cmd_ready, 0);
    @(posedge clk);
    #1;
    chk("sim_not_taken", rsp_valid, 0);
    chk("sim_ready1", cmd_ready, 1);
    @(posedge clk);
    #1;
    chk("sim_rv2", rsp_valid, 1);
    cmd_valid = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
